register_lane_permute: RTL and testbench

- Parametrised, pipelined successor to the 16-bit byte-swap stage between ALU result and register write-back.
- Permutes LANES lanes of LANE_W bits under a per-beat mode: pass, half-swap, lane reverse, or rotate.
- Sits behind a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept under back-pressure.
- Data keeps the active-low (not-) convention of the ALU result path; the block never changes bit polarity.

---
 rtl/register_lane_permute_if.sv | 27 ++
 rtl/register_lane_permute.sv | 102 ++++++++++
 tb/tb_register_lane_permute.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_lane_permute_if.sv
// Handshake bundle for register_lane_permute.
// Upstream beat, downstream beat and the accepted-beat counter.
interface register_lane_permute_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int RW     = $clog2(LANES)
) ();
  logic [LANE_W*LANES-1:0] notDataIn;
  logic [1:0]              Mode;
  logic [RW-1:0]           RotAmt;
  logic                    In_Valid;
  logic                    In_Ready;
  logic [LANE_W*LANES-1:0] notDataOut;
  logic                    Out_Valid;
  logic                    Out_Ready;
  logic [15:0]             BeatCount;

  modport master (
    output notDataIn, Mode, RotAmt, In_Valid, Out_Ready,
    input  In_Ready, notDataOut, Out_Valid, BeatCount
  );

  modport slave (
    input  notDataIn, Mode, RotAmt, In_Valid, Out_Ready,
    output In_Ready, notDataOut, Out_Valid, BeatCount
  );
endinterface

// File: rtl/register_lane_permute.sv
// Lane permute stage between ALU result and write-back.
// Pass / half-swap / reverse / rotate-left, 2-entry skid buffer.
module register_lane_permute #(
  parameter  int LANE_W = 8,
  parameter  int LANES  = 2,
  localparam int RW     = $clog2(LANES)
) (
  input logic CLK,
  input logic RST,
  register_lane_permute_if.slave bus
);

  localparam int W = LANE_W * LANES;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } buf_t;

  buf_t         state;
  logic [W-1:0] or_q;
  logic [W-1:0] sk_q;
  logic         ov_q;
  logic         rdy_q;
  logic [15:0]  cnt_q;
  logic [W-1:0] perm;
  logic         acc;
  logic         dlv;

  // Lane-granular mux; index arithmetic wraps in RW bits (LANES is 2^RW).
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [RW-1:0] src;
    always_comb begin
      src = RW'(g);
      unique case (bus.Mode)
        2'b00:   src = RW'(g);
        2'b01:   src = RW'(g + LANES/2);
        2'b10:   src = ~RW'(g);
        default: src = RW'(g) - bus.RotAmt;
      endcase
    end
    assign perm[g*LANE_W +: LANE_W] =
      bus.notDataIn[src*LANE_W +: LANE_W];
  end

  assign acc = bus.In_Valid && rdy_q;
  assign dlv = ov_q && bus.Out_Ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
      or_q  <= '1;
      sk_q  <= '1;
      ov_q  <= 1'b0;
      rdy_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      if (acc)
        cnt_q <= cnt_q + 16'd1;
      unique case (state)
        EMPTY: begin
          if (acc) begin
            or_q  <= perm;
            ov_q  <= 1'b1;
            state <= ONE;
          end
        end
        ONE: begin
          if (acc && dlv) begin
            or_q <= perm;
          end else if (acc) begin
            sk_q  <= perm;
            rdy_q <= 1'b0;
            state <= FULL;
          end else if (dlv) begin
            ov_q  <= 1'b0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (dlv) begin
            or_q  <= sk_q;
            rdy_q <= 1'b1;
            state <= ONE;
          end
        end
        default: begin
          ov_q  <= 1'b0;
          rdy_q <= 1'b1;
          state <= EMPTY;
        end
      endcase
    end
  end

  assign bus.In_Ready   = rdy_q;
  assign bus.Out_Valid  = ov_q;
  assign bus.notDataOut = or_q;
  assign bus.BeatCount  = cnt_q;

endmodule

// File: tb/tb_register_lane_permute.sv
// Bench for register_lane_permute: scoreboard on the 16-bit
// instance, directed lane checks on a 4-lane instance.
module tb_register_lane_permute;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_lane_permute_if #(.LANE_W(8), .LANES(2)) d ();
  register_lane_permute_if #(.LANE_W(8), .LANES(4)) q ();

  register_lane_permute #(.LANE_W(8), .LANES(2)) dut (
    .CLK(clk), .RST(rst), .bus(d)
  );
  register_lane_permute #(.LANE_W(8), .LANES(4)) dut4 (
    .CLK(clk), .RST(rst), .bus(q)
  );

  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  function automatic logic [15:0] model(
    input logic [15:0] x, input logic [1:0] m, input logic r);
    logic sw;
    sw = (m == 2'b01) || (m == 2'b10) || (m == 2'b11 && r);
    return sw ? {x[7:0], x[15:8]} : x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    d.notDataIn = 16'($urandom);
    d.Mode      = 2'($urandom);
    d.RotAmt    = 1'($urandom);
  endtask

  // Scoreboard: expectation queued on accept, checked on deliver.
  always @(negedge clk) begin
    if (!rst) begin
      if (d.Out_Valid && d.Out_Ready) begin
        n_out++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_extra got=%h want=none", d.notDataOut);
        end else begin
          exp_w = sb.pop_front();
          if (d.notDataOut !== exp_w) begin
            bad++;
            $display("FAIL sb_data got=%h want=%h",
                     d.notDataOut, exp_w);
          end
        end
      end
      if (d.In_Valid && d.In_Ready) begin
        sb.push_back(model(d.notDataIn, d.Mode, d.RotAmt));
        n_in++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    d.In_Valid  = 1'b0;
    d.Out_Ready = 1'b0;
    q.In_Valid  = 1'b0;
    q.Out_Ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (d.Out_Valid !== 1'b0) begin
      bad++; $display("FAIL rst_ov got=%b want=0", d.Out_Valid);
    end
    if (d.In_Ready !== 1'b1) begin
      bad++; $display("FAIL rst_ir got=%b want=1", d.In_Ready);
    end
    if (d.notDataOut !== 16'hFFFF) begin
      bad++; $display("FAIL rst_data got=%h want=ffff", d.notDataOut);
    end
    if (d.BeatCount !== 16'h0000) begin
      bad++; $display("FAIL rst_cnt got=%h want=0000", d.BeatCount);
    end
    if (q.notDataOut !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rst_data4 got=%h want=ffffffff",
                      q.notDataOut);
    end
  endtask

  task automatic test_swap();
    d.Out_Ready = 1'b1;
    d.notDataIn = 16'h12AB;
    d.Mode      = 2'b01;
    d.RotAmt    = 1'b0;
    d.In_Valid  = 1'b1;
    step();
    d.In_Valid = 1'b0;
    total += 3;
    if (d.Out_Valid !== 1'b1) begin
      bad++; $display("FAIL swap_ov got=%b want=1", d.Out_Valid);
    end
    if (d.notDataOut !== 16'hAB12) begin
      bad++; $display("FAIL swap_data got=%h want=ab12", d.notDataOut);
    end
    if (d.BeatCount !== 16'd1) begin
      bad++; $display("FAIL swap_cnt got=%0d want=1", d.BeatCount);
    end
    step();
  endtask

  task automatic test_lanes4();
    logic [1:0]  ms[5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b11};
    logic [1:0]  rs[5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3};
    logic [31:0] es[5] = '{32'h11223344, 32'h33221144, 32'h44332211,
                           32'h22114433, 32'h11443322};
    for (int k = 0; k < 5; k++) begin
      q.notDataIn = 32'h44332211;
      q.Mode      = ms[k];
      q.RotAmt    = rs[k];
      q.In_Valid  = 1'b1;
      step();
      q.In_Valid = 1'b0;
      total++;
      if (q.Out_Valid !== 1'b1 || q.notDataOut !== es[k]) begin
        bad++;
        $display("FAIL lanes4_%0d got=%b/%h want=1/%h",
                 k, q.Out_Valid, q.notDataOut, es[k]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [4:0] ov;
    logic       acc;
    int         o0;
    do_reset();
    d.Out_Ready = 1'b0;
    d.Mode      = 2'b00;
    d.RotAmt    = 1'b0;
    d.notDataIn = 16'h0001;
    d.In_Valid  = 1'b1;
    step();
    d.notDataIn = 16'h0002;
    step();
    total++;
    if (d.In_Ready !== 1'b0) begin
      bad++; $display("FAIL bp_full_ir got=%b want=0", d.In_Ready);
    end
    d.notDataIn = 16'h0003;
    step();
    step();
    step();
    total += 3;
    if (d.In_Ready !== 1'b0) begin
      bad++; $display("FAIL bp_hold_ir got=%b want=0", d.In_Ready);
    end
    if (d.Out_Valid !== 1'b1 || d.notDataOut !== 16'h0001) begin
      bad++; $display("FAIL bp_hold_data got=%b/%h want=1/0001",
                      d.Out_Valid, d.notDataOut);
    end
    if (d.BeatCount !== 16'd2) begin
      bad++; $display("FAIL bp_hold_cnt got=%0d want=2", d.BeatCount);
    end
    o0 = n_out;
    d.Out_Ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ov[k] = d.Out_Valid;
      acc   = d.In_Valid && d.In_Ready;
      @(posedge clk);
      #1;
      if (acc) d.In_Valid = 1'b0;
    end
    total += 3;
    if (ov !== 5'b00111) begin
      bad++; $display("FAIL bp_drain_ov got=%b want=00111", ov);
    end
    if (n_out - o0 != 3) begin
      bad++; $display("FAIL bp_drain_n got=%0d want=3", n_out - o0);
    end
    if (d.BeatCount !== 16'd3) begin
      bad++; $display("FAIL bp_drain_cnt got=%0d want=3", d.BeatCount);
    end
  endtask

  task automatic test_stream();
    int i0;
    int o0;
    int lows;
    do_reset();
    i0 = n_in;
    o0 = n_out;
    lows = 0;
    d.Out_Ready = 1'b1;
    rand_beat();
    d.In_Valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d.In_Ready !== 1'b1) lows++;
      @(posedge clk);
      #1;
      rand_beat();
    end
    d.In_Valid = 1'b0;
    total += 3;
    if (lows != 0) begin
      bad++; $display("FAIL stream_ir got=%0d want=0 low cycles", lows);
    end
    if (n_in - i0 != 100) begin
      bad++; $display("FAIL stream_in got=%0d want=100", n_in - i0);
    end
    if (d.BeatCount !== 16'd100) begin
      bad++; $display("FAIL stream_cnt got=%0d want=100", d.BeatCount);
    end
    step();
    total++;
    if (n_out - o0 != 100) begin
      bad++; $display("FAIL stream_out got=%0d want=100", n_out - o0);
    end
  endtask

  task automatic test_reset_full();
    int o0;
    int stale;
    do_reset();
    d.Out_Ready = 1'b0;
    d.Mode      = 2'b00;
    d.notDataIn = 16'hAAAA;
    d.In_Valid  = 1'b1;
    step();
    d.notDataIn = 16'h5555;
    step();
    d.notDataIn = 16'h7777;
    rst = 1'b1;
    step();
    rst = 1'b0;
    d.In_Valid = 1'b0;
    sb.delete();
    total += 4;
    if (d.Out_Valid !== 1'b0) begin
      bad++; $display("FAIL rf_ov got=%b want=0", d.Out_Valid);
    end
    if (d.In_Ready !== 1'b1) begin
      bad++; $display("FAIL rf_ir got=%b want=1", d.In_Ready);
    end
    if (d.notDataOut !== 16'hFFFF) begin
      bad++; $display("FAIL rf_data got=%h want=ffff", d.notDataOut);
    end
    if (d.BeatCount !== 16'd0) begin
      bad++; $display("FAIL rf_cnt got=%0d want=0", d.BeatCount);
    end
    o0 = n_out;
    stale = 0;
    d.Out_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d.Out_Valid !== 1'b0) stale++;
      @(posedge clk);
      #1;
    end
    total++;
    if (stale != 0 || n_out != o0) begin
      bad++; $display("FAIL rf_stale got=%0d want=0 valid cycles", stale);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    d.Out_Ready = 1'b1;
    rand_beat();
    d.In_Valid = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      @(posedge clk);
      #1;
      if (k == 65534) begin
        total++;
        if (d.BeatCount !== 16'hFFFF) begin
          bad++; $display("FAIL wrap_max got=%h want=ffff", d.BeatCount);
        end
      end
      rand_beat();
    end
    d.In_Valid = 1'b0;
    total++;
    if (d.BeatCount !== 16'h0000) begin
      bad++; $display("FAIL wrap_zero got=%h want=0000", d.BeatCount);
    end
    step();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL wrap_drain got=%0d want=0 pending", sb.size());
    end
  endtask

  initial begin
    d.notDataIn = '0;
    d.Mode      = 2'b00;
    d.RotAmt    = '0;
    d.In_Valid  = 1'b0;
    d.Out_Ready = 1'b0;
    q.notDataIn = '0;
    q.Mode      = 2'b00;
    q.RotAmt    = '0;
    q.In_Valid  = 1'b0;
    q.Out_Ready = 1'b1;
    test_reset();
    test_swap();
    test_lanes4();
    test_backpressure();
    test_stream();
    test_reset_full();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
